// File: rtl/seed_ram_arbiter.sv
// Round-robin arbiter sharing the single-port Toeplitz seed RAM between host writes and the seed reader.
// Grants one cycle after a request is sampled in IDLE; reads return RD_LAT cycles after the grant; requesters hold req until gnt.
module seed_ram_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2,
  parameter int WORDS  = 96
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              addr_err,
  input  logic              seed_clr,
  output logic              seed_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W  = $clog2(WORDS + 1);
  localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, WR, RD, RWAIT} state_t;

  state_t              state_q, state_d;
  logic                prio_rd_q, prio_rd_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic                rd_err_q, rd_err_d;
  logic                wr_gnt_q, wr_gnt_d;
  logic                rd_gnt_q, rd_gnt_d;
  logic                rd_valid_q, rd_valid_d;
  logic                addr_err_q, addr_err_d;
  logic                ram_we_q, ram_we_d;
  logic                ram_re_q, ram_re_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;

  logic wr_in, rd_in, grant_wr, grant_rd, cap;

  assign wr_in = ({1'b0, wr_addr} < (ADDR_W+1)'(WORDS));
  assign rd_in = ({1'b0, rd_addr} < (ADDR_W+1)'(WORDS));

  always_comb begin
    state_d     = state_q;
    prio_rd_d   = prio_rd_q;
    wait_d      = wait_q;
    cnt_d       = cnt_q;
    ready_d     = ready_q;
    rd_err_d    = rd_err_q;
    wr_gnt_d    = 1'b0;
    rd_gnt_d    = 1'b0;
    rd_valid_d  = 1'b0;
    addr_err_d  = 1'b0;
    ram_we_d    = 1'b0;
    ram_re_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    rd_data_d   = rd_data_q;
    grant_wr    = 1'b0;
    grant_rd    = 1'b0;
    cap         = 1'b0;

    case (state_q)
      IDLE: begin
        // On contention the side that was not granted last wins
        grant_wr = wr_req && (!rd_req || !prio_rd_q);
        grant_rd = rd_req && !grant_wr;
        if (grant_wr) begin
          state_d     = WR;
          prio_rd_d   = 1'b1;
          wr_gnt_d    = 1'b1;
          ram_we_d    = wr_in;
          addr_err_d  = !wr_in;
          ram_addr_d  = wr_addr;
          ram_wdata_d = wr_data;
          if (wr_in && !ready_q) begin
            cnt_d   = cnt_q + CNT_W'(1);
            ready_d = (cnt_q == CNT_W'(WORDS - 1));
          end
        end else if (grant_rd) begin
          state_d    = RD;
          prio_rd_d  = 1'b0;
          rd_gnt_d   = 1'b1;
          ram_re_d   = rd_in;
          addr_err_d = !rd_in;
          rd_err_d   = !rd_in;
          ram_addr_d = rd_addr;
        end
      end
      WR: state_d = IDLE;
      RD: begin
        state_d = RWAIT;
        wait_d  = WAIT_W'(RD_LAT - 1);
        cap     = (RD_LAT == 1);
      end
      RWAIT: begin
        // ram_rdata is sampled on the edge RD_LAT cycles after ram_re rose
        if (wait_q == '0) begin
          state_d = IDLE;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
          cap    = (wait_q == WAIT_W'(1));
        end
      end
      default: state_d = IDLE;
    endcase

    if (cap) begin
      rd_valid_d = 1'b1;
      rd_data_d  = rd_err_q ? '0 : ram_rdata;
    end

    if (seed_clr) begin
      cnt_d   = '0;
      ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      prio_rd_q   <= 1'b0;
      wait_q      <= '0;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      rd_err_q    <= 1'b0;
      wr_gnt_q    <= 1'b0;
      rd_gnt_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      addr_err_q  <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_re_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      prio_rd_q   <= prio_rd_d;
      wait_q      <= wait_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      rd_err_q    <= rd_err_d;
      wr_gnt_q    <= wr_gnt_d;
      rd_gnt_q    <= rd_gnt_d;
      rd_valid_q  <= rd_valid_d;
      addr_err_q  <= addr_err_d;
      ram_we_q    <= ram_we_d;
      ram_re_q    <= ram_re_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign wr_gnt     = wr_gnt_q;
  assign rd_gnt     = rd_gnt_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign addr_err   = addr_err_q;
  assign seed_ready = ready_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign ram_we     = ram_we_q;
  assign ram_re     = ram_re_q;

endmodule

// File: tb/tb_seed_ram_arbiter.sv
// Scoreboard bench for seed_ram_arbiter: stimulus queues expected grants/read returns, a monitor pops and compares them.
module tb_seed_ram_arbiter;
  localparam int RD_LAT = 2;

  logic        clk_in = 1'b0;
  logic        rst = 1'b0;
  logic        wr_req = 1'b0, rd_req = 1'b0, seed_clr = 1'b0;
  logic [6:0]  wr_addr = '0, rd_addr = '0;
  logic [31:0] wr_data = '0;
  logic        wr_gnt, rd_gnt, rd_valid, addr_err, seed_ready, ram_we, ram_re;
  logic [31:0] rd_data, ram_wdata, ram_rdata;
  logic [6:0]  ram_addr;

  seed_ram_arbiter #(.ADDR_W(7), .DATA_W(32), .RD_LAT(RD_LAT), .WORDS(96)) dut (
    .clk_in(clk_in), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_data(rd_data), .rd_valid(rd_valid),
    .addr_err(addr_err), .seed_clr(seed_clr), .seed_ready(seed_ready),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re), .ram_rdata(ram_rdata)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // RAM model: one register stage, so data sampled by the DUT RD_LAT=2 edges after ram_re rises
  logic [31:0] mem [128];
  logic [31:0] rdata_q;
  always @(posedge clk_in) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) rdata_q <= mem[ram_addr];
  end
  assign ram_rdata = rdata_q;

  typedef struct {
    int          kind;   // 0 wr_gnt, 1 rd_gnt, 2 rd_valid
    int          cyc;
    logic [6:0]  addr;
    logic [31:0] data;
    logic        err;
    logic        strb;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] exp_mem [128];
  int          checks = 0;
  int          errors = 0;

  exp_t me;
  int   mk;
  logic mok;
  always @(negedge clk_in) begin
    if (!rst && (wr_gnt || rd_gnt || rd_valid)) begin
      mk = wr_gnt ? 0 : (rd_gnt ? 1 : 2);
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event kind %0d at cyc %0d, none expected", mk, cyc);
      end else begin
        me  = sbq.pop_front();
        mok = (mk == me.kind) && (cyc == me.cyc);
        case (me.kind)
          0: mok = mok && (ram_addr == me.addr) && (ram_we == me.strb) && (addr_err == me.err)
                   && !ram_re && (!me.strb || ram_wdata == me.data);
          1: mok = mok && (ram_addr == me.addr) && (ram_re == me.strb) && (addr_err == me.err) && !ram_we;
          default: mok = mok && (rd_data === me.data);
        endcase
        if (!mok) begin
          errors++;
          $display("FAIL event got kind %0d cyc %0d addr %0d wdata %h rdata %h err %b we %b re %b; want kind %0d cyc %0d addr %0d data %h err %b strb %b",
                   mk, cyc, ram_addr, ram_wdata, rd_data, addr_err, ram_we, ram_re,
                   me.kind, me.cyc, me.addr, me.data, me.err, me.strb);
        end
      end
    end
  end

  task automatic push(input int k, input int c, input logic [6:0] a, input logic [31:0] d,
                      input logic e, input logic s);
    exp_t x;
    x.kind = k; x.cyc = c; x.addr = a; x.data = d; x.err = e; x.strb = s;
    sbq.push_back(x);
  endtask

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, req);
    end
  endtask

  task automatic do_wr(input logic [6:0] a, input logic [31:0] d, input logic clr, output logic rdy);
    logic in_r, got;
    in_r = (a < 7'd96);
    @(posedge clk_in); #1;
    wr_req = 1'b1; wr_addr = a; wr_data = d; seed_clr = clr;
    push(0, cyc + 1, a, d, !in_r, in_r);
    if (in_r) exp_mem[a] = d;
    rdy = 1'b0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk_in); #1;
      seed_clr = 1'b0;
      if (wr_gnt) begin got = 1'b1; rdy = seed_ready; end
    end
    wr_req = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL wr_timeout addr %0d got no wr_gnt want wr_gnt", a); end
  endtask

  task automatic do_rd(input logic [6:0] a);
    logic in_r, got;
    int   c;
    in_r = (a < 7'd96);
    @(posedge clk_in); #1;
    c = cyc;
    rd_req = 1'b1; rd_addr = a;
    push(1, c + 1, a, 32'h0, !in_r, in_r);
    push(2, c + 1 + RD_LAT, a, in_r ? exp_mem[a] : 32'h0, 1'b0, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk_in); #1;
      if (rd_gnt) got = 1'b1;
    end
    rd_req = 1'b0;
    for (int i = 0; i < 20 && !rd_valid; i++) begin
      @(posedge clk_in); #1;
    end
    checks++;
    if (!got || !rd_valid) begin
      errors++;
      $display("FAIL rd_timeout addr %0d got gnt %b valid %b want 1 1", a, got, rd_valid);
    end
  endtask

  logic        r;
  int          c;
  logic [31:0] d3;

  initial begin
    for (int i = 0; i < 128; i++) begin mem[i] = 32'h0; exp_mem[i] = 32'h0; end
    #2 rst = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    chk("reset_outputs", {wr_gnt, rd_gnt, rd_valid, addr_err, seed_ready, ram_we, ram_re,
                          ram_addr, ram_wdata, rd_data}, '0);
    rst = 1'b0;

    // single write then read back
    do_wr(7'd5, 32'hDEADBEEF, 1'b0, r);
    @(posedge clk_in); #1;
    chk("t1_strobes_n2", {wr_gnt, ram_we}, '0);
    do_rd(7'd5);

    // both requesters held high right after reset: W,R,W,R
    @(posedge clk_in); #1; rst = 1'b1;
    @(posedge clk_in); #1; rst = 1'b0;
    @(posedge clk_in); #1;
    c  = cyc;
    d3 = 32'h1234_5678;
    wr_req = 1'b1; wr_addr = 7'd10; wr_data = d3;
    rd_req = 1'b1; rd_addr = 7'd10;
    exp_mem[10] = d3;
    push(0, c + 1,  7'd10, d3, 1'b0, 1'b1);
    push(1, c + 3,  7'd10, 32'h0, 1'b0, 1'b1);
    push(2, c + 5,  7'd10, d3, 1'b0, 1'b0);
    push(0, c + 7,  7'd10, d3, 1'b0, 1'b1);
    push(1, c + 9,  7'd10, 32'h0, 1'b0, 1'b1);
    push(2, c + 11, 7'd10, d3, 1'b0, 1'b0);
    while (cyc < c + 11) begin @(posedge clk_in); #1; end
    wr_req = 1'b0; rd_req = 1'b0;

    // seed load, out-of-range accesses, saturation
    @(posedge clk_in); #1; seed_clr = 1'b1;
    @(posedge clk_in); #1; seed_clr = 1'b0;
    chk("t4_clr_initial", seed_ready, 0);
    for (int i = 0; i < 95; i++) do_wr(7'(i), 32'hC0DE0000 | i, 1'b0, r);
    chk("t4_ready_at_95", r, 0);
    do_wr(7'd100, 32'hBAD0BAD0, 1'b0, r);
    chk("t5_ready_after_err_wr", r, 0);
    do_wr(7'd95, 32'hC0DE005F, 1'b0, r);
    chk("t4_ready_at_96", r, 1);
    do_wr(7'd0, 32'h00000A0A, 1'b0, r);
    chk("t4_ready_saturate", r, 1);
    do_rd(7'd50);
    do_rd(7'd100);
    do_rd(7'd0);
    @(posedge clk_in); #1;
    chk("t4_ready_before_clr", seed_ready, 1);
    seed_clr = 1'b1;
    @(posedge clk_in); #1; seed_clr = 1'b0;
    chk("t4_ready_after_clr", seed_ready, 0);

    // seed_clr coincident with the 96th write wins
    for (int i = 0; i < 95; i++) do_wr(7'(i), 32'h5EED0000 | i, 1'b0, r);
    do_wr(7'd95, 32'h5EED005F, 1'b1, r);
    chk("t4_clr_wins_over_wr", r, 0);
    for (int i = 0; i < 95; i++) do_wr(7'(i), 32'hA5A50000 | i, 1'b0, r);
    chk("t4_recount_95", r, 0);
    do_wr(7'd95, 32'hA5A5005F, 1'b0, r);
    chk("t4_recount_96", r, 1);

    // reset while a read is in RWAIT
    @(posedge clk_in); #1;
    c = cyc;
    rd_req = 1'b1; rd_addr = 7'd20;
    push(1, c + 1, 7'd20, 32'h0, 1'b0, 1'b1);
    @(posedge clk_in); #1;
    rd_req = 1'b0;
    @(posedge clk_in); #2;
    rst = 1'b1;
    #1;
    chk("t6_outputs_zero_in_rst", {wr_gnt, rd_gnt, rd_valid, addr_err, seed_ready, ram_we, ram_re,
                                   ram_addr, ram_wdata, rd_data}, '0);
    repeat (2) @(posedge clk_in);
    #1; rst = 1'b0;
    repeat (4) @(posedge clk_in);
    #1;
    chk("t6_no_rd_valid", {rd_valid, rd_data}, '0);

    // write granted last, then reset: contest must still go to write
    do_wr(7'd30, 32'h3030_3030, 1'b0, r);
    @(posedge clk_in); #1; rst = 1'b1;
    @(posedge clk_in); #1; rst = 1'b0;
    @(posedge clk_in); #1;
    c  = cyc;
    d3 = 32'h3131_3131;
    wr_req = 1'b1; wr_addr = 7'd31; wr_data = d3;
    rd_req = 1'b1; rd_addr = 7'd31;
    exp_mem[31] = d3;
    push(0, c + 1, 7'd31, d3, 1'b0, 1'b1);
    @(posedge clk_in); #1;
    chk("t6_contest_w_gnt", {wr_gnt, rd_gnt}, 2'b10);
    wr_req = 1'b0; rd_req = 1'b0;

    repeat (6) @(posedge clk_in);
    #1;
    chk("scoreboard_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
